// File: rtl/sub_nibble_serial.sv
// -----------------------------------------------------------------------------
// sub_nibble_serial
//   Nibble-serial WIDTH-bit subtractor. Computes din1 - din2 (mod 2^WIDTH)
//   four bits per cycle through a single 4-bit subtract slice. The slice
//   borrow is chained between cycles, so one flat-width carry chain is
//   replaced by NIBBLES iterations of a 4-bit one.
//
//   Handshake: valid/ready on both sides. Operands are captured only on the
//   accept edge (in_valid && in_ready). The result stays in DONE, held
//   stable, until the consumer asserts out_ready.
//
//   Timing: out_valid rises NIBBLES+1 edges after the accept edge (the accept
//   edge counts as the first). No overlap between operations.
//
// Parameters
//   WIDTH      operand/result width, a multiple of 4 and >= 8
//
// Optional feature
//   SUBSER_OVF_EN  when defined, adds the ovf output (signed overflow of the
//                  subtraction), registered together with the result.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (IDLE and not in reset)
//   din1       in   minuend
//   din2       in   subtrahend
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   dout       out  din1 - din2, modulo 2^WIDTH
//   bout       out  borrow, 1 when din1 < din2 (unsigned)
//   ovf        out  signed overflow (SUBSER_OVF_EN only)
// -----------------------------------------------------------------------------
module sub_nibble_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             bout
`ifdef SUBSER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cin;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [4:0]         slice;
`ifdef SUBSER_OVF_EN
  logic               msb1;
  logic               msb2;
`endif

  // 4-bit subtract slice, implemented as a + ~b + bin. The "bin" input is
  // really a carry-in (1 = no borrow pending), and the returned borrow is
  // the inverted carry-out. Result packing: {borrow, diff[3:0]}.
  function automatic logic [4:0] sub_4bit(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       bin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, ~b} + {4'b0000, bin};
    return {~s[4], s[3:0]};
  endfunction

  always_comb begin
    slice = sub_4bit(op1[3:0], op2[3:0], cin);
  end

  // Depends only on state and reset so the upstream can never see a
  // combinational path from its own in_valid back to in_ready.
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cin       <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
      bout      <= 1'b0;
`ifdef SUBSER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op1   <= din1;
            op2   <= din2;
            cnt   <= '0;
            cin   <= 1'b1;
`ifdef SUBSER_OVF_EN
            msb1  <= din1[WIDTH-1];
            msb2  <= din2[WIDTH-1];
`endif
            state <= RUN;
          end
        end

        RUN: begin
          // Result nibbles enter at the MSB end; after NIBBLES shifts the
          // first (least significant) nibble has reached bit 0.
          dout <= {slice[3:0], dout[WIDTH-1:4]};
          op1  <= op1 >> 4;
          op2  <= op2 >> 4;
          cin  <= ~slice[4];
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_NIB) begin
            bout      <= slice[4];
`ifdef SUBSER_OVF_EN
            // slice[3] is the result MSB being shifted in on this edge.
            ovf       <= (msb1 != msb2) && (slice[3] != msb1);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_nibble_serial.sv
// -----------------------------------------------------------------------------
// tb_sub_nibble_serial
//   Directed and random checks of the nibble-serial subtractor (WIDTH=16):
//   reset state, latency, known differences and borrows, backpressure hold,
//   mid-operation reset, and random back-to-back operations against a model.
// -----------------------------------------------------------------------------
module tb_sub_nibble_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din1;
  logic [15:0] din2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        bout;
`ifdef SUBSER_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sub_nibble_serial #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din1      (din1),
    .din2      (din2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .bout      (bout)
`ifdef SUBSER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete operation: offer, accept, wait (bounded) for the result,
  // compare against the reference, then pop it.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input bit early_ready, input string tag);
    logic [15:0] exp_d;
    logic        exp_b;
    logic        exp_o;
    int          n;
    exp_d = a - b;
    exp_b = (a < b);
    exp_o = (a[15] != b[15]) && (exp_d[15] != a[15]);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid  = 1'b1;
    din1      = a;
    din2      = b;
    out_ready = early_ready;
    tick;
    in_valid = 1'b0;
    din1     = 16'($urandom);
    din2     = 16'($urandom);
    check({tag, "_in_ready_busy"}, in_ready, 0);
    n = 1;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_dout"}, dout, exp_d);
    check({tag, "_bout"}, bout, exp_b);
`ifdef SUBSER_OVF_EN
    check({tag, "_ovf"}, ovf, exp_o);
`else
    if (exp_o) begin end
`endif
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_popped"}, out_valid, 0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din1      = 16'h0;
    din2      = 16'h0;

    // Reset state
    tick;
    tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 16'h0000);
    check("rst_bout", bout, 0);
    check("rst_in_ready_low", in_ready, 0);
`ifdef SUBSER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    #1;
    check("rst_in_ready_high", in_ready, 1);

    // Directed vectors; out_ready held high early in the first one
    run_op(16'h1234, 16'h0234, 1'b1, "t1");
    run_op(16'h0000, 16'h0001, 1'b0, "t2");
    run_op(16'h8000, 16'h0001, 1'b0, "t3a");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, "t3b");

    // Backpressure: result held for 10 cycles while new in_valid is offered
    in_valid = 1'b1;
    din1     = 16'hA5A5;
    din2     = 16'h5A5A;
    tick;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    check("bp_latency", n, 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      din1     = 16'h0000;
      din2     = 16'h0001;
      tick;
      check("bp_valid", out_valid, 1);
      check("bp_dout", dout, 16'h4B4B);
      check("bp_bout", bout, 0);
      check("bp_in_ready", in_ready, 0);
`ifdef SUBSER_OVF_EN
      check("bp_ovf", ovf, 1);
`endif
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("bp_pop_valid", out_valid, 0);
    check("bp_pop_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick;
      check("bp_no_ghost_op", out_valid, 0);
    end

    // Reset during the second RUN cycle discards the operation
    in_valid = 1'b1;
    din1     = 16'h1234;
    din2     = 16'h0001;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      check("mid_rst_no_pulse", out_valid, 0);
    end
    run_op(16'hFFFF, 16'hFFFF, 1'b0, "t5");

    // Random back-to-back operations
    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
